dlbf_data_play_sched: RTL

- Central playback scheduler for the four DLBF data BRAM-to-AXIS channels, in the m_axis_clk domain, after the CSR-to-stream CDC.
- Latches the run configuration (go, niter, block_size, rollover_addr) and issues lock-step BRAM read commands (address, enable, last-of-block) to all enabled channels.
- Issues a command only when every enabled channel can accept a word. Reports busy/done/iteration status back toward the CSR path.

---
 rtl/dlbf_data_play_sched_if.sv | 25 ++
 rtl/dlbf_data_play_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dlbf_data_play_sched_if.sv
// BRAM read-command bus between the playback scheduler and the DLBF data channels.
// The scheduler drives lock-step read strobes; each channel reports buffer space back.
interface dlbf_data_play_sched_if #(
   parameter int NCH        = 4,
   parameter int ADDR_WIDTH = 16
);
   logic [NCH-1:0]        rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_last;
   logic [NCH-1:0]        ch_ready;

   modport master (
      output rd_en,
      output rd_addr,
      output rd_last,
      input  ch_ready
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      input  rd_last,
      output ch_ready
   );
endinterface

// File: rtl/dlbf_data_play_sched.sv
// Central playback scheduler for the DLBF data BRAM-to-AXIS channels (m_axis_clk domain).
// Latches a run configuration on a go rising edge and issues lock-step read commands.
module dlbf_data_play_sched #(
   parameter int NCH        = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 12
) (
   input  logic                  m_axis_clk,
   input  logic                  m_axis_rst,
   input  logic                  go,
   input  logic [NCH-1:0]        ch_en,
   input  logic [CNT_WIDTH-1:0]  niter,
   input  logic [CNT_WIDTH-1:0]  block_size,
   input  logic [ADDR_WIDTH-1:0] rollover_addr,
   dlbf_data_play_sched_if.master rd,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic [CNT_WIDTH-1:0]  iter_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  go_q, go_q_d;
   logic                  go_arm_q, go_arm_d;
   logic [NCH-1:0]        en_lat_q, en_lat_d;
   logic [CNT_WIDTH-1:0]  niter_lat_q, niter_lat_d;
   logic [CNT_WIDTH-1:0]  bsize_lat_q, bsize_lat_d;
   logic [ADDR_WIDTH-1:0] roll_lat_q, roll_lat_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic [CNT_WIDTH-1:0]  iter_q, iter_d;
   logic                  stop_q, stop_d;
   logic [NCH-1:0]        rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_last_q, rd_last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  cfg_err_q, cfg_err_d;

   logic                  go_rise;
   logic                  issue;
   logic                  last_word;
   logic [CNT_WIDTH-1:0]  iter_inc;
   logic                  run_end;

   // go must be seen low after reset before an edge counts, so a go held through reset cannot start a run.
   assign go_rise   = go && !go_q && go_arm_q;
   assign issue     = (state_q == S_RUN) && (&(rd.ch_ready | ~en_lat_q));
   assign last_word = (word_cnt_q == bsize_lat_q - CNT_WIDTH'(1));
   assign iter_inc  = iter_q + CNT_WIDTH'(1);
   // Finite runs end on the niter-th block; continuous runs end on the block during which go fell.
   assign run_end   = (niter_lat_q != '0) ? (iter_inc == niter_lat_q) : (stop_q || !go);

   // NOTE: every signal assigned here gets its default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      go_q_d      = go;
      go_arm_d    = go_arm_q | ~go;
      en_lat_d    = en_lat_q;
      niter_lat_d = niter_lat_q;
      bsize_lat_d = bsize_lat_q;
      roll_lat_d  = roll_lat_q;
      addr_d      = addr_q;
      word_cnt_d  = word_cnt_q;
      iter_d      = iter_q;
      stop_d      = stop_q;
      rd_en_d     = '0;
      rd_addr_d   = rd_addr_q;
      rd_last_d   = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;
      cfg_err_d   = cfg_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (go_rise) state_d = S_LOAD;
         end

         S_LOAD: begin
            en_lat_d    = ch_en;
            niter_lat_d = niter;
            bsize_lat_d = block_size;
            roll_lat_d  = rollover_addr;
            if ((block_size == '0) || (ch_en == '0)) begin
               cfg_err_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cfg_err_d  = 1'b0;
               busy_d     = 1'b1;
               addr_d     = '0;
               word_cnt_d = '0;
               iter_d     = '0;
               stop_d     = 1'b0;
               state_d    = S_RUN;
            end
         end

         S_RUN: begin
            if (!go) stop_d = 1'b1;
            if (issue) begin
               rd_en_d   = en_lat_q;
               rd_addr_d = addr_q;
               rd_last_d = last_word;
               addr_d    = (addr_q == roll_lat_q) ? '0 : addr_q + ADDR_WIDTH'(1);
               if (last_word) begin
                  word_cnt_d = '0;
                  iter_d     = iter_inc;
                  if (run_end) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end else begin
                  word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
               end
            end
         end

         S_DONE: begin
            if (!go) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
      if (m_axis_rst) begin
         state_q     <= S_IDLE;
         go_q        <= 1'b0;
         go_arm_q    <= 1'b0;
         en_lat_q    <= '0;
         niter_lat_q <= '0;
         bsize_lat_q <= '0;
         roll_lat_q  <= '0;
         addr_q      <= '0;
         word_cnt_q  <= '0;
         iter_q      <= '0;
         stop_q      <= 1'b0;
         rd_en_q     <= '0;
         rd_addr_q   <= '0;
         rd_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         go_q        <= go_q_d;
         go_arm_q    <= go_arm_d;
         en_lat_q    <= en_lat_d;
         niter_lat_q <= niter_lat_d;
         bsize_lat_q <= bsize_lat_d;
         roll_lat_q  <= roll_lat_d;
         addr_q      <= addr_d;
         word_cnt_q  <= word_cnt_d;
         iter_q      <= iter_d;
         stop_q      <= stop_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         rd_last_q   <= rd_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign rd.rd_en   = rd_en_q;
   assign rd.rd_addr = rd_addr_q;
   assign rd.rd_last = rd_last_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;
   assign iter_cnt   = iter_q;

endmodule
